// File: rtl/cricket_score_keeper_if.sv
// Delivery/score bus between the entry logic and the scorekeeper.
//   master: upstream button/entry logic (drives deliveries, reads score)
//   slave : the scorekeeper (consumes deliveries, drives score/match state)
// Signals:
//   ball_valid     one-cycle pulse, one delivery
//   ball_runs      runs on the delivery (0-6, 7 = illegal/discard)
//   ball_wicket    delivery took a wicket, sampled with ball_valid
//   next_inning    one-cycle pulse, start innings 2
//   binary_runs    batting side's runs
//   binary_wickets batting side's wickets
//   balls_bowled   legal balls this innings
//   inning_over    high during the innings break
//   game_over      high once the match is decided
//   winner         0 = team 1, 1 = team 2 (valid with game_over)
//   tie            scores level at the end of the match
interface cricket_score_keeper_if;
    logic       ball_valid;
    logic [2:0] ball_runs;
    logic       ball_wicket;
    logic       next_inning;
    logic [7:0] binary_runs;
    logic [3:0] binary_wickets;
    logic [7:0] balls_bowled;
    logic       inning_over;
    logic       game_over;
    logic       winner;
    logic       tie;

    modport master (
        output ball_valid, ball_runs, ball_wicket, next_inning,
        input  binary_runs, binary_wickets, balls_bowled,
               inning_over, game_over, winner, tie
    );

    modport slave (
        input  ball_valid, ball_runs, ball_wicket, next_inning,
        output binary_runs, binary_wickets, balls_bowled,
               inning_over, game_over, winner, tie
    );
endinterface

// File: rtl/cricket_score_keeper.sv
// Two-innings limited-overs scorekeeper feeding the BCD display path.
// Accumulates runs/wickets/legal balls per delivery, sequences
// INN1 -> BREAK -> INN2 -> DONE and decides winner/tie.
// Ports:
//   clk   system clock
//   reset synchronous, active-high
//   sk    delivery/score bus (slave side), see cricket_score_keeper_if
// Parameters:
//   MAX_WICKETS wickets ending an innings (1-15)
//   MAX_BALLS   legal balls per innings (1-255)
// Every output is a register; a delivery sampled on an edge, including
// any state change it causes, is visible right after that edge.
module cricket_score_keeper #(
    parameter int MAX_WICKETS = 10,
    parameter int MAX_BALLS   = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    cricket_score_keeper_if.slave  sk
);

    typedef enum logic [1:0] {INN1, BREAK, INN2, DONE} state_t;

    localparam logic [3:0] WKT_LIMIT  = 4'(MAX_WICKETS);
    localparam logic [7:0] BALL_LIMIT = 8'(MAX_BALLS);

    state_t     state, state_nxt;
    logic [7:0] runs, runs_nxt;
    logic [3:0] wkts, wkts_nxt;
    logic [7:0] balls, balls_nxt;
    logic [8:0] target, target_nxt;
    logic       inning_over, inning_over_nxt;
    logic       game_over, game_over_nxt;
    logic       winner, winner_nxt;
    logic       tie, tie_nxt;

    // Candidate figures if the current delivery is accepted.
    logic [8:0] runs_sum;
    logic [7:0] runs_acc;
    logic [3:0] wkts_acc;
    logic [7:0] balls_acc;
    logic       innings_end;
    logic       accept;

    always_comb begin
        runs_sum    = {1'b0, runs} + {6'b0, sk.ball_runs};
        // Runs saturate at 255 rather than wrapping.
        runs_acc    = runs_sum[8] ? 8'hFF : runs_sum[7:0];
        wkts_acc    = wkts + {3'b0, sk.ball_wicket};
        balls_acc   = balls + 8'd1;
        innings_end = (wkts_acc == WKT_LIMIT) || (balls_acc == BALL_LIMIT);
        // ball_runs = 7 is a bad entry: drop the whole delivery.
        accept      = sk.ball_valid && (sk.ball_runs != 3'd7);
    end

    always_comb begin
        state_nxt       = state;
        runs_nxt        = runs;
        wkts_nxt        = wkts;
        balls_nxt       = balls;
        target_nxt      = target;
        inning_over_nxt = inning_over;
        game_over_nxt   = game_over;
        winner_nxt      = winner;
        tie_nxt         = tie;

        case (state)
            INN1: begin
                if (accept) begin
                    runs_nxt  = runs_acc;
                    wkts_nxt  = wkts_acc;
                    balls_nxt = balls_acc;
                    if (innings_end) begin
                        // 9-bit so a 255 first innings chases 256.
                        target_nxt      = {1'b0, runs_acc} + 9'd1;
                        state_nxt       = BREAK;
                        inning_over_nxt = 1'b1;
                    end
                end
            end
            BREAK: begin
                // Team 1 figures stay on display until the chase starts.
                if (sk.next_inning) begin
                    runs_nxt        = '0;
                    wkts_nxt        = '0;
                    balls_nxt       = '0;
                    state_nxt       = INN2;
                    inning_over_nxt = 1'b0;
                end
            end
            INN2: begin
                if (accept) begin
                    runs_nxt  = runs_acc;
                    wkts_nxt  = wkts_acc;
                    balls_nxt = balls_acc;
                    // Reaching the target wins even on the last wicket/ball.
                    if ({1'b0, runs_acc} >= target) begin
                        state_nxt     = DONE;
                        game_over_nxt = 1'b1;
                        winner_nxt    = 1'b1;
                        tie_nxt       = 1'b0;
                    end else if (innings_end) begin
                        state_nxt     = DONE;
                        game_over_nxt = 1'b1;
                        winner_nxt    = 1'b0;
                        tie_nxt       = ({1'b0, runs_acc} == (target - 9'd1));
                    end
                end
            end
            DONE: begin
                // Terminal until reset.
            end
            default: begin
                state_nxt = INN1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INN1;
            runs        <= '0;
            wkts        <= '0;
            balls       <= '0;
            target      <= '0;
            inning_over <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            tie         <= 1'b0;
        end else begin
            state       <= state_nxt;
            runs        <= runs_nxt;
            wkts        <= wkts_nxt;
            balls       <= balls_nxt;
            target      <= target_nxt;
            inning_over <= inning_over_nxt;
            game_over   <= game_over_nxt;
            winner      <= winner_nxt;
            tie         <= tie_nxt;
        end
    end

    assign sk.binary_runs    = runs;
    assign sk.binary_wickets = wkts;
    assign sk.balls_bowled   = balls;
    assign sk.inning_over    = inning_over;
    assign sk.game_over      = game_over;
    assign sk.winner         = winner;
    assign sk.tie            = tie;

endmodule

// File: tb/tb_cricket_score_keeper.sv
// Scoreboard bench: two scorekeepers (12-ball and 60-ball innings).
// Each cycle the reference outcome is pushed when stimulus is driven and
// popped/compared against the DUT just after the clock edge.
module tb_cricket_score_keeper;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    cricket_score_keeper_if ifa ();
    cricket_score_keeper_if ifb ();

    cricket_score_keeper #(.MAX_WICKETS(10), .MAX_BALLS(12)) dut_a (
        .clk(clk), .reset(rst_a), .sk(ifa.slave));
    cricket_score_keeper #(.MAX_WICKETS(10), .MAX_BALLS(60)) dut_b (
        .clk(clk), .reset(rst_b), .sk(ifb.slave));

    typedef struct {
        int runs;
        int wkts;
        int balls;
        int target;
        int st;      // 0 INN1, 1 BREAK, 2 INN2, 3 DONE
        bit winner;
        bit tie;
    } model_t;

    model_t ma, mb;
    model_t sbq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic model_t model_step(model_t m, bit rs, bit bv, int r,
                                          bit w, bit ni, int maxb);
        model_t n = m;
        int rn, wn, bn;
        bit fin;
        if (rs) begin
            n = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
            return n;
        end
        if (bv && r != 7 && (m.st == 0 || m.st == 2)) begin
            rn = (m.runs + r > 255) ? 255 : m.runs + r;
            wn = m.wkts + int'(w);
            bn = m.balls + 1;
            fin = (wn == 10) || (bn == maxb);
            n.runs = rn; n.wkts = wn; n.balls = bn;
            if (m.st == 0 && fin) begin
                n.target = rn + 1;
                n.st = 1;
            end else if (m.st == 2) begin
                if (rn >= m.target) begin
                    n.st = 3; n.winner = 1'b1; n.tie = 1'b0;
                end else if (fin) begin
                    n.st = 3; n.winner = 1'b0; n.tie = (rn == m.target - 1);
                end
            end
        end else if (ni && m.st == 1) begin
            n.runs = 0; n.wkts = 0; n.balls = 0; n.st = 2;
        end
        return n;
    endfunction

    task automatic cyc(input string tag, input bit sel, input bit rs, input bit bv,
                       input int r, input bit w, input bit ni);
        model_t e;
        if (sel) begin
            mb = model_step(mb, rs, bv, r, w, ni, 60);
            sbq.push_back(mb);
        end else begin
            ma = model_step(ma, rs, bv, r, w, ni, 12);
            sbq.push_back(ma);
        end
        @(negedge clk);
        if (sel) begin
            rst_b = rs; ifb.ball_valid = bv; ifb.ball_runs = 3'(r);
            ifb.ball_wicket = w; ifb.next_inning = ni;
        end else begin
            rst_a = rs; ifa.ball_valid = bv; ifa.ball_runs = 3'(r);
            ifa.ball_wicket = w; ifa.next_inning = ni;
        end
        @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.ball_valid = 1'b0; ifa.ball_wicket = 1'b0; ifa.next_inning = 1'b0; ifa.ball_runs = 3'd0;
        ifb.ball_valid = 1'b0; ifb.ball_wicket = 1'b0; ifb.next_inning = 1'b0; ifb.ball_runs = 3'd0;
        e = sbq.pop_front();
        chk({tag, ".runs"},  sel ? int'(ifb.binary_runs)    : int'(ifa.binary_runs),    e.runs);
        chk({tag, ".wkts"},  sel ? int'(ifb.binary_wickets) : int'(ifa.binary_wickets), e.wkts);
        chk({tag, ".balls"}, sel ? int'(ifb.balls_bowled)   : int'(ifa.balls_bowled),   e.balls);
        chk({tag, ".brk"},   sel ? int'(ifb.inning_over)    : int'(ifa.inning_over),    int'(e.st == 1));
        chk({tag, ".done"},  sel ? int'(ifb.game_over)      : int'(ifa.game_over),      int'(e.st == 3));
        chk({tag, ".win"},   sel ? int'(ifb.winner)         : int'(ifa.winner),         int'(e.winner));
        chk({tag, ".tie"},   sel ? int'(ifb.tie)            : int'(ifa.tie),            int'(e.tie));
    endtask

    task automatic ball(input string tag, input bit sel, input int r, input bit w);
        cyc(tag, sel, 1'b0, 1'b1, r, w, 1'b0);
    endtask

    // Reset DUT A, team 1 makes 24 off 12 balls, start innings 2.
    task automatic team1_24();
        cyc("rst", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) ball("t1", 1'b0, 2, 1'b0);
        cyc("ni", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.ball_valid = 1'b0; ifa.ball_runs = 3'd0; ifa.ball_wicket = 1'b0; ifa.next_inning = 1'b0;
        ifb.ball_valid = 1'b0; ifb.ball_runs = 3'd0; ifb.ball_wicket = 1'b0; ifb.next_inning = 1'b0;
        ma = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
        mb = ma;
        cyc("rst_a", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        cyc("rst_b", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("reset_runs", int'(ifa.binary_runs), 0);
        chk("reset_done", int'(ifa.game_over), 0);

        // Three scoring balls.
        ball("b4", 1'b0, 4, 1'b0);
        ball("b6", 1'b0, 6, 1'b0);
        ball("b1", 1'b0, 1, 1'b0);
        chk("three_runs", int'(ifa.binary_runs), 11);
        chk("three_balls", int'(ifa.balls_bowled), 3);

        // Full first innings, deliveries ignored in the break.
        cyc("rst", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) ball("inn1", 1'b0, 2, 1'b0);
        chk("inn1_brk", int'(ifa.inning_over), 1);
        chk("inn1_runs", int'(ifa.binary_runs), 24);
        ball("brk_ign", 1'b0, 3, 1'b1);
        chk("brk_hold", int'(ifa.binary_runs), 24);
        cyc("ni", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("ni_clear", int'(ifa.binary_runs), 0);

        // Chase succeeds on the 25th run.
        for (int i = 0; i < 4; i++) ball("chase6", 1'b0, 6, 1'b0);
        chk("chase_open", int'(ifa.game_over), 0);
        ball("chase1", 1'b0, 1, 1'b0);
        chk("chase_win", int'(ifa.winner), 1);
        chk("chase_runs", int'(ifa.binary_runs), 25);
        ball("done_ign", 1'b0, 4, 1'b0);
        cyc("done_ni", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("done_hold", int'(ifa.binary_runs), 25);

        // All out for 20 with run-outs scoring.
        team1_24();
        for (int i = 0; i < 10; i++) ball("allout", 1'b0, 2, 1'b1);
        chk("allout_done", int'(ifa.game_over), 1);
        chk("allout_win", int'(ifa.winner), 0);
        chk("allout_tie", int'(ifa.tie), 0);
        chk("allout_wkts", int'(ifa.binary_wickets), 10);

        // Level scores on the last ball.
        team1_24();
        for (int i = 0; i < 12; i++) ball("tie", 1'b0, 2, 1'b0);
        chk("tie_flag", int'(ifa.tie), 1);
        chk("tie_done", int'(ifa.game_over), 1);

        // Reset in the middle of the chase.
        team1_24();
        ball("mid6", 1'b0, 6, 1'b0);
        ball("mid6", 1'b0, 6, 1'b0);
        ball("mid5", 1'b0, 5, 1'b0);
        chk("mid_runs", int'(ifa.binary_runs), 17);
        cyc("mid_rst", 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("mid_rst_runs", int'(ifa.binary_runs), 0);
        ball("resume", 1'b0, 3, 1'b0);
        chk("resume_runs", int'(ifa.binary_runs), 3);

        // Saturation on the long-innings instance.
        cyc("rst", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 43; i++) ball("sat", 1'b1, 6, 1'b0);
        chk("sat_runs", int'(ifb.binary_runs), 255);
        ball("bad7", 1'b1, 7, 1'b1);
        chk("bad7_balls", int'(ifb.balls_bowled), 43);
        chk("bad7_wkts", int'(ifb.binary_wickets), 0);
        for (int i = 0; i < 17; i++) ball("dots", 1'b1, 0, 1'b0);
        chk("sat_brk", int'(ifb.inning_over), 1);
        cyc("ni", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 43; i++) ball("sat2", 1'b1, 6, 1'b0);
        chk("sat2_open", int'(ifb.game_over), 0);
        for (int i = 0; i < 17; i++) ball("dots2", 1'b1, 0, 1'b0);
        chk("sat2_tie", int'(ifb.tie), 1);
        chk("sat2_win", int'(ifb.winner), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cricket_score_keeper.md
Name: cricket_score_keeper

Overview:
- Sequential scorekeeper that produces the score and match-state signals consumed by the score-to-BCD display converter.
- Accumulates runs, wickets and legal balls per delivery event for a two-innings, limited-overs match.
- Sequences innings 1 → break → innings 2 → game over, and decides the winner.
- Sits between the debounced button/entry logic (upstream) and the BCD/7-segment display path (downstream).

Parameters:
- MAX_WICKETS, 10, wickets that end an innings (legal range 1–15)
- MAX_BALLS, 12, legal balls per innings (overs × 6, legal range 1–255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ball_valid  in  1  one-cycle pulse, one delivery
- ball_runs  in  3  runs scored on the delivery (0–6; 7 is illegal)
- ball_wicket  in  1  delivery took a wicket; sampled with ball_valid
- next_inning  in  1  one-cycle pulse, start innings 2
- binary_runs  out  8  current batting side's runs
- binary_wickets  out  4  current batting side's wickets
- balls_bowled  out  8  legal balls this innings
- inning_over  out  1  high only in BREAK
- game_over  out  1  high only in DONE
- winner  out  1  0 = team 1, 1 = team 2; valid when game_over = 1
- tie  out  1  high in DONE when scores are level

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state = INN1; all outputs 0; internal target register = 0.
- Reset mid-operation: a reset in any state returns to INN1 with all counters cleared on that edge.
- Registered outputs: all outputs come from registers. A ball sampled on edge N is visible after edge N. This includes any resulting state change, so there is no extra cycle of latency.

Delivery acceptance:
- ball_valid is accepted only in INN1 and INN2. It is ignored in BREAK and DONE.
- A delivery with ball_runs = 7 is discarded entirely: no runs, wicket or ball counted.

Accepted delivery:
- runs_next = min(binary_runs + ball_runs, 255). Runs saturate at 255 and never wrap.
- wickets_next = binary_wickets + ball_wicket. Runs and wicket both apply on the same ball, so a run-out with runs is allowed.
- balls_next = balls_bowled + 1.
- All end-of-innings checks use the _next values.

State machine:
- INN1 → BREAK when wickets_next == MAX_WICKETS or balls_next == MAX_BALLS.
  - Same edge: target <= runs_next + 1 (9-bit).
  - Same edge: inning_over = 1.
  - binary_runs, binary_wickets and balls_bowled hold team 1's final figures.
- BREAK → INN2 on next_inning.
  - Same edge: runs, wickets and balls clear to 0; inning_over = 0.
- next_inning in any state other than BREAK is ignored.
- INN2 → DONE, evaluated in this priority order:
  - (a) runs_next >= target: winner = 1, tie = 0. This wins even if the same ball is the last wicket or last ball.
  - (b) otherwise, on the last wicket or last ball:
    - if runs_next == target − 1: tie = 1, winner = 0;
    - else: winner = 0, tie = 0.
- On entering DONE: game_over = 1; team 2's final figures hold.
- DONE is terminal until reset.
- Simultaneous ball_valid and next_inning: they can never both be acted on, because each is accepted in a different state.

Width rules:
- Target is 9 bits, so team 1 = 255 gives target 256.
- Team 2 can then never win because runs saturate at 255. At 255 with innings ended, tie = 1.
- Wicket counter is 4 bits; it cannot exceed MAX_WICKETS because the innings ends on reaching it.

Test Plan:
- Reset, then 3 balls (4, 6, 1 runs, no wicket) → binary_runs = 11, balls_bowled = 3, binary_wickets = 0, inning_over = 0; each update visible one cycle after its ball_valid.
- INN1 with MAX_BALLS = 12, 12 balls of 2 runs → on the 12th ball, inning_over = 1 and runs = 24 hold; further ball_valid pulses change nothing; next_inning clears runs/wickets/balls to 0 and inning_over = 0.
- Team 1 = 24; INN2 balls of 6, 6, 6, 6, then 1 → game_over asserts on the 25-run ball with winner = 1 and runs = 25; later ball_valid and next_inning are ignored.
- Team 1 = 24; INN2 takes 10 wickets with 20 runs before the last ball → game_over = 1, winner = 0, tie = 0, binary_wickets = 10. Repeat with team 2 reaching exactly 24 on the last ball → tie = 1, winner = 0.
- Saturation: team 1 scores 43 × 6 runs → binary_runs = 255 (no wrap). Also: a ball with ball_runs = 7 → no counter changes.
- Reset asserted mid-INN2 (runs = 17) → next cycle all outputs 0, state INN1; normal scoring resumes.
